event_feeder: RTL and testbench

- Upstream stage of the two-channel event counter. It produces that counter's En/Slt strobe pair.
- Takes two raw, asynchronous event lines and synchronises each one. Each rising edge on a line becomes one pending event for that channel.
- Pending events are queued as per-channel counts and issued one per clock as a registered En pulse, with Slt naming the channel.
- Round-robin arbitration, a stall input, and saturation/drop accounting keep bursts from being silently lost.

---
 rtl/event_feeder.sv | 122 ++++++++++++
 tb/tb_event_feeder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/event_feeder.sv
// Event feeder: synchronises two raw event lines, queues rising edges as per-channel
// pending counts and issues them one per clock as a registered En/Slt strobe pair.
module event_feeder #(
    parameter int CNT_W  = 4,
    parameter int DROP_W = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Evt0,
    input  logic              Evt1,
    input  logic              Hold,
    input  logic              Clear,
    output logic              En,
    output logic              Slt,
    output logic [CNT_W-1:0]  Pend0,
    output logic [CNT_W-1:0]  Pend1,
    output logic              Overflow,
    output logic [DROP_W-1:0] DropCnt
);

    localparam logic [CNT_W-1:0]  PEND_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    logic [1:0]        s1, s2, s3;
    logic [1:0]        rise;
    logic              last;
    logic              grant_valid;
    logic              grant_ch;
    logic [1:0]        grant;
    logic [CNT_W-1:0]  pend_nxt0, pend_nxt1;
    logic [1:0]        drop;
    logic [DROP_W:0]   drop_sum;
    logic [DROP_W-1:0] drop_nxt;

    // Synchronisers are untouched by Clear so a level still high cannot re-trigger.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            s1 <= 2'b00;
            s2 <= 2'b00;
            s3 <= 2'b00;
        end else begin
            s1 <= {Evt1, Evt0};
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    always_comb begin
        grant_valid = 1'b0;
        grant_ch    = 1'b0;
        if (!Hold) begin
            if ((Pend0 != '0) && (Pend1 != '0)) begin
                grant_valid = 1'b1;
                grant_ch    = ~last;
            end else if (Pend0 != '0) begin
                grant_valid = 1'b1;
                grant_ch    = 1'b0;
            end else if (Pend1 != '0) begin
                grant_valid = 1'b1;
                grant_ch    = 1'b1;
            end
        end
    end

    assign grant = {grant_valid & grant_ch, grant_valid & ~grant_ch};

    // A rise arriving with the counter full and no grant to make room is dropped.
    always_comb begin
        pend_nxt0 = Pend0;
        pend_nxt1 = Pend1;
        drop      = 2'b00;
        if (rise[0] && !grant[0]) begin
            if (Pend0 == PEND_MAX) drop[0] = 1'b1;
            else                   pend_nxt0 = Pend0 + CNT_ONE;
        end else if (!rise[0] && grant[0]) begin
            pend_nxt0 = Pend0 - CNT_ONE;
        end
        if (rise[1] && !grant[1]) begin
            if (Pend1 == PEND_MAX) drop[1] = 1'b1;
            else                   pend_nxt1 = Pend1 + CNT_ONE;
        end else if (!rise[1] && grant[1]) begin
            pend_nxt1 = Pend1 - CNT_ONE;
        end
        drop_sum = {1'b0, DropCnt} + {{DROP_W{1'b0}}, drop[0]} + {{DROP_W{1'b0}}, drop[1]};
        drop_nxt = drop_sum[DROP_W] ? DROP_MAX : drop_sum[DROP_W-1:0];
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            En       <= 1'b0;
            Slt      <= 1'b0;
            last     <= 1'b1;
            Pend0    <= '0;
            Pend1    <= '0;
            Overflow <= 1'b0;
            DropCnt  <= '0;
        end else if (Clear) begin
            En       <= 1'b0;
            last     <= 1'b1;
            Pend0    <= '0;
            Pend1    <= '0;
            Overflow <= 1'b0;
            DropCnt  <= '0;
        end else begin
            En    <= grant_valid;
            Pend0 <= pend_nxt0;
            Pend1 <= pend_nxt1;
            if (grant_valid) begin
                Slt  <= grant_ch;
                last <= grant_ch;
            end
            if (drop != 2'b00) begin
                Overflow <= 1'b1;
                DropCnt  <= drop_nxt;
            end
        end
    end

endmodule

// File: tb/tb_event_feeder.sv
// Directed bench for event_feeder: latency, arbitration, saturation, clear and reset.
module tb_event_feeder;

    logic        Clk;
    logic        Reset;
    logic        Evt0, Evt1, Hold, Clear;
    logic        En, Slt;
    logic [3:0]  Pend0, Pend1;
    logic        Overflow;
    logic [15:0] DropCnt;

    int n_checks;
    int n_pass;
    int en_cnt;
    int slt_bad;

    event_feeder #(.CNT_W(4), .DROP_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .Evt0(Evt0), .Evt1(Evt1), .Hold(Hold),
        .Clear(Clear), .En(En), .Slt(Slt), .Pend0(Pend0), .Pend1(Pend1),
        .Overflow(Overflow), .DropCnt(DropCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // One clean edge on a channel: 2 sampling edges high, 2 low.
    task automatic pulse(input int ch);
        if (ch == 0) Evt0 = 1'b1; else Evt1 = 1'b1;
        ticks(2);
        if (ch == 0) Evt0 = 1'b0; else Evt1 = 1'b0;
        ticks(2);
    endtask

    task automatic conflict_pair(input string tag);
        Evt0 = 1'b1; Evt1 = 1'b1;
        ticks(2);
        tick();
        chk({tag, "_pend0"}, 32'(Pend0), 32'd1);
        chk({tag, "_pend1"}, 32'(Pend1), 32'd1);
        tick();
        chk({tag, "_en_a"}, 32'(En), 32'd1);
        chk({tag, "_slt_a"}, 32'(Slt), 32'd0);
        tick();
        chk({tag, "_en_b"}, 32'(En), 32'd1);
        chk({tag, "_slt_b"}, 32'(Slt), 32'd1);
        Evt0 = 1'b0; Evt1 = 1'b0;
        tick();
        chk({tag, "_en_c"}, 32'(En), 32'd0);
        ticks(3);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        Reset = 1'b0; Evt0 = 1'b0; Evt1 = 1'b0; Hold = 1'b0; Clear = 1'b0;

        // Reset state
        ticks(2);
        chk("rst_en", 32'(En), 32'd0);
        chk("rst_pend0", 32'(Pend0), 32'd0);
        chk("rst_dropcnt", 32'(DropCnt), 32'd0);
        Reset = 1'b1;
        ticks(2);

        // Single event latency
        Evt0 = 1'b1;
        ticks(2);
        tick();
        chk("single_pend_k2", 32'(Pend0), 32'd1);
        chk("single_en_k2", 32'(En), 32'd0);
        tick();
        chk("single_en_k3", 32'(En), 32'd1);
        chk("single_slt_k3", 32'(Slt), 32'd0);
        chk("single_pend_k3", 32'(Pend0), 32'd0);
        tick();
        Evt0 = 1'b0;
        chk("single_en_k4", 32'(En), 32'd0);
        en_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (En) en_cnt++;
        end
        chk("single_no_more_en", 32'(en_cnt), 32'd0);

        // Conflict: clear first so Last=1 as after reset
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        conflict_pair("conf1");
        conflict_pair("conf2");

        // Saturation under Hold
        Hold = 1'b1;
        for (int i = 0; i < 20; i++) pulse(0);
        ticks(3);
        chk("sat_pend0", 32'(Pend0), 32'd15);
        chk("sat_overflow", 32'(Overflow), 32'd1);
        chk("sat_dropcnt", 32'(DropCnt), 32'd5);
        chk("sat_en_held", 32'(En), 32'd0);
        Hold = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("sat_drain_en", 32'(En), 32'd1);
            chk("sat_drain_slt", 32'(Slt), 32'd0);
            chk("sat_drain_pend", 32'(Pend0), 32'(14 - i));
        end
        tick();
        chk("sat_end_en", 32'(En), 32'd0);
        chk("sat_end_pend0", 32'(Pend0), 32'd0);
        chk("sat_end_overflow", 32'(Overflow), 32'd1);
        chk("sat_end_dropcnt", 32'(DropCnt), 32'd5);

        // Rise coinciding with a grant on the same channel
        Hold = 1'b1;
        for (int i = 0; i < 3; i++) pulse(0);
        ticks(3);
        chk("rg_setup_pend0", 32'(Pend0), 32'd3);
        Evt0 = 1'b1;
        ticks(2);
        Hold = 1'b0;
        tick();
        chk("rg_pend0", 32'(Pend0), 32'd3);
        chk("rg_en", 32'(En), 32'd1);
        Evt0 = 1'b0;
        ticks(3);
        chk("rg_drain_pend0", 32'(Pend0), 32'd0);
        chk("rg_drain_en", 32'(En), 32'd1);
        tick();
        chk("rg_idle_en", 32'(En), 32'd0);

        // Clear: build Pend0=4, Pend1=2, DropCnt=7
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        chk("clr0_dropcnt", 32'(DropCnt), 32'd0);
        chk("clr0_overflow", 32'(Overflow), 32'd0);
        Hold = 1'b1;
        for (int i = 0; i < 22; i++) pulse(0);
        ticks(3);
        Hold = 1'b0;
        ticks(11);
        Hold = 1'b1;
        pulse(1);
        pulse(1);
        ticks(3);
        chk("clr_setup_pend0", 32'(Pend0), 32'd4);
        chk("clr_setup_pend1", 32'(Pend1), 32'd2);
        chk("clr_setup_dropcnt", 32'(DropCnt), 32'd7);
        Evt1 = 1'b1;
        ticks(2);
        Clear = 1'b1;
        Hold  = 1'b0;
        tick();
        Clear = 1'b0;
        chk("clr_pend0", 32'(Pend0), 32'd0);
        chk("clr_pend1", 32'(Pend1), 32'd0);
        chk("clr_dropcnt", 32'(DropCnt), 32'd0);
        chk("clr_overflow", 32'(Overflow), 32'd0);
        chk("clr_en", 32'(En), 32'd0);
        ticks(4);
        chk("clr_level_no_retrig", 32'(Pend1), 32'd0);
        Evt1 = 1'b0;
        ticks(4);
        chk("clr_after_en", 32'(En), 32'd0);

        // Reset mid-burst, then a held level gives one fresh event
        Hold = 1'b1;
        for (int i = 0; i < 5; i++) pulse(0);
        ticks(3);
        Hold = 1'b0;
        tick();
        chk("mid_burst_en", 32'(En), 32'd1);
        Evt0 = 1'b1;
        #2;
        Reset = 1'b0;
        #1;
        chk("mid_rst_en", 32'(En), 32'd0);
        chk("mid_rst_pend0", 32'(Pend0), 32'd0);
        chk("mid_rst_pend1", 32'(Pend1), 32'd0);
        chk("mid_rst_overflow", 32'(Overflow), 32'd0);
        chk("mid_rst_dropcnt", 32'(DropCnt), 32'd0);
        @(negedge Clk);
        Reset = 1'b1;
        en_cnt  = 0;
        slt_bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (En) begin
                en_cnt++;
                if (Slt !== 1'b0) slt_bad++;
            end
        end
        chk("post_rst_en_count", 32'(en_cnt), 32'd1);
        chk("post_rst_slt", 32'(slt_bad), 32'd0);
        Evt0 = 1'b0;
        ticks(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
